uart_echo_fifo: RTL and testbench
=================================

// Module: uart_echo_fifo
// PURPOSE
//   Buffered, parametrised UART echo engine between UartRX and UartTX.
//   Drains received words into a DEPTH-entry FIFO and replays them to the transmitter in order.
//   Back-to-back RX bursts are not lost while TX is busy, up to DEPTH words.
//   Replaces ad-hoc single-word echo glue in Hack top levels; status outputs drive LEDs.
// PARAMETERS
//   WIDTH        16  data word width; matches UartRX OUT / UartTX IN
//   DEPTH        8   FIFO entries; power of two, >=2
//   DROP_NEWEST  1   1: word arriving while full is discarded, OVERFLOW set; 0: RX is back-pressured
// PORTS
//   CLK_100MHz  in   1                   single system clock, all logic on posedge
//   RESET       in   1                   synchronous, active-high
//   RX_DATA     in   WIDTH               UartRX OUT
//   RX_READY    in   1                   UartRX RX_READY; level, held until CLEAR
//   RX_CLEAR    out  1                   to UartRX CLEAR
//   TX_DATA     out  WIDTH               to UartTX IN
//   TX_LOAD     out  1                   to UartTX LOAD
//   TX_BUSY     in   1                   UartTX TX_BUSY
//   FLUSH       in   1                   discard FIFO contents; synchronous, one-cycle effect
//   COUNT       out  $clog2(DEPTH+1)     current occupancy
//   EMPTY/FULL  out  1                   COUNT==0 / COUNT==DEPTH
//   OVERFLOW    out  1                   sticky; a word was dropped since reset/FLUSH
// BEHAVIOUR
//   Reset: RX_CLEAR=0, TX_LOAD=0, TX_DATA=0, COUNT=0, EMPTY=1, FULL=0, OVERFLOW=0;
//     both FSMs go to IDLE; pointers=0. Applies mid-transfer; a frame already in UartTX is not recalled.
//   RX FSM
//     R_IDLE: RX_READY && !FULL -> push RX_DATA, RX_CLEAR<=1, go R_ACK.
//       RX_READY && FULL: DROP_NEWEST=1 -> no push, OVERFLOW<=1, RX_CLEAR<=1, go R_ACK.
//       DROP_NEWEST=0 -> stay, RX_CLEAR=0; UartRX keeps holding the word.
//     R_ACK: RX_CLEAR<=0; go R_IDLE once RX_READY==0.
//       Prevents a still-high RX_READY being pushed twice.
//   TX FSM
//     T_IDLE: !EMPTY && !TX_BUSY -> TX_DATA<=head, TX_LOAD<=1, pop, go T_START.
//     T_START: hold TX_LOAD=1 until TX_BUSY==1; then TX_LOAD<=0, go T_DONE.
//     T_DONE: TX_BUSY==0 -> T_IDLE.
//     Inter-word gap is at most 2 cycles after TX_BUSY falls.
//   Latency: RX_READY rise -> RX_CLEAR high at +1; word visible in COUNT at +1.
//     Empty FIFO, idle TX: push at cycle N -> TX_LOAD high at N+1 (first-word fall-through).
//   Simultaneous push+pop: COUNT unchanged. Pop from FULL while a word waits: push allowed next cycle.
//   Pointers wrap modulo DEPTH; COUNT never exceeds DEPTH or underflows.
//   FLUSH: pointers=0, COUNT=0, OVERFLOW=0.
//     Overrides a same-cycle push; the pushed word is lost and does not set OVERFLOW.
//     A word already loaded into TX completes; the TX FSM is not reset.
//   RX and TX FSMs are independent; data order is strictly FIFO.
// CONFIGURATION
//   ECHO_UPPERCASE_EN defined: bits [7:0] in 8'h61..8'h7A have bit5 cleared at TX_DATA load ('a'->'A').
//     Upper bits and all other values pass through; stored data is unmodified.
//   ECHO_UPPERCASE_EN undefined: TX_DATA is a bit-exact copy of the received word.
// TESTING
//   Single word 16'h0041, TX idle -> RX_CLEAR pulse, TX_LOAD high next cycle, TX_DATA=16'h0041, COUNT back to 0.
//   Burst of 8 words 1..8 while TX_BUSY held high -> FULL=1, COUNT=8; release busy -> replay 1..8 in order, EMPTY=1.
//   DROP_NEWEST=1, 9th word 16'h00FF while full -> word dropped, OVERFLOW=1, RX_CLEAR pulsed, COUNT stays 8.
//   DROP_NEWEST=0, 9th word while full -> RX_CLEAR stays 0; after one pop, word pushed; OVERFLOW stays 0.
//   FLUSH with COUNT=5 and OVERFLOW=1 -> next cycle COUNT=0, EMPTY=1, OVERFLOW=0, no further TX_LOAD.
//   ECHO_UPPERCASE_EN: 'a','Z','{' (16'h61,5A,7B) -> TX 16'h41,5A,7B; macro off -> 16'h61,5A,7B.
//     RESET mid-T_START -> TX_LOAD=0, COUNT=0.

Source files
------------

// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo: buffered UART echo engine. Words from UartRX are queued in
// a DEPTH-entry FIFO and replayed in order to UartTX. Bursts that arrive while
// TX is busy are held, up to DEPTH words.
//
// Optional feature macro: ECHO_UPPERCASE_EN. When defined, a word whose low
// byte is 'a'..'z' is sent with bit 5 cleared. The stored copy is unchanged.
//
// Parameters : WIDTH (word width), DEPTH (power of two, >=2),
//              DROP_NEWEST (1: drop the word when full, 0: back-pressure RX)
// Ports      : i_clk_100mhz, i_reset (sync, active-high)
//              i_rx_data/i_rx_ready/o_rx_clear  - UartRX handshake
//              o_tx_data/o_tx_load/i_tx_busy    - UartTX handshake
//              i_flush                          - discard FIFO contents
//              o_count/o_empty/o_full/o_overflow - status (LEDs)
module uart_echo_fifo #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned DROP_NEWEST = 1
) (
  input  logic                       i_clk_100mhz,
  input  logic                       i_reset,
  input  logic [WIDTH-1:0]           i_rx_data,
  input  logic                       i_rx_ready,
  output logic                       o_rx_clear,
  output logic [WIDTH-1:0]           o_tx_data,
  output logic                       o_tx_load,
  input  logic                       i_tx_busy,
  input  logic                       i_flush,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_empty,
  output logic                       o_full,
  output logic                       o_overflow
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic       {R_IDLE, R_ACK}           rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DONE} tx_state_t;

  rx_state_t        r_rx_state;
  tx_state_t        r_tx_state;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_empty;
  logic             r_full;
  logic             r_overflow;
  logic             r_rx_clear;
  logic             r_tx_load;
  logic [WIDTH-1:0] r_tx_data;

  logic             w_rx_req;
  logic             w_accept;
  logic             w_push;
  logic             w_drop;
  logic             w_pop;
  logic [CW-1:0]    w_count_nxt;
  logic [WIDTH-1:0] w_head;

  // Transform applied to a word as it is handed to the transmitter.
  function automatic logic [WIDTH-1:0] f_echo(input logic [WIDTH-1:0] d);
`ifdef ECHO_UPPERCASE_EN
    f_echo = d;
    if ((d[7:0] >= 8'h61) && (d[7:0] <= 8'h7A)) f_echo[5] = 1'b0;
`else
    f_echo = d;
`endif
  endfunction

  // RX accepts (acks) a word either by storing it or, in drop mode, discarding it.
  // A flush in the same cycle still acks the word but suppresses the store.
  assign w_rx_req = (r_rx_state == R_IDLE) && i_rx_ready;
  assign w_accept = w_rx_req && !r_full;
  assign w_push   = w_accept && !i_flush;
  assign w_drop   = w_rx_req && r_full && (DROP_NEWEST != 0);
  assign w_pop    = (r_tx_state == T_IDLE) && !r_empty && !i_tx_busy && !i_flush;
  assign w_head   = r_mem[r_rptr];

  // Next occupancy; flush wins over any same-cycle push/pop.
  always_comb begin
    w_count_nxt = r_count;
    if (i_flush)              w_count_nxt = '0;
    else if (w_push && !w_pop) w_count_nxt = r_count + CW'(1);
    else if (!w_push && w_pop) w_count_nxt = r_count - CW'(1);
  end

  // Storage array (no reset needed; occupancy tracks validity).
  always_ff @(posedge i_clk_100mhz) begin
    if (!i_reset && w_push) r_mem[r_wptr] <= i_rx_data;
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge i_clk_100mhz) begin
    if (i_reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == CW'(DEPTH));
      if (i_flush) begin
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_push) r_wptr <= r_wptr + AW'(1);
        if (w_pop)  r_rptr <= r_rptr + AW'(1);
        if (w_drop) r_overflow <= 1'b1;
      end
    end
  end

  // RX FSM: ack once, then wait for RX_READY to drop so a held word is not re-pushed.
  always_ff @(posedge i_clk_100mhz) begin
    if (i_reset) begin
      r_rx_state <= R_IDLE;
      r_rx_clear <= 1'b0;
    end else begin
      case (r_rx_state)
        R_IDLE: begin
          r_rx_clear <= 1'b0;
          if (w_accept || w_drop) begin
            r_rx_clear <= 1'b1;
            r_rx_state <= R_ACK;
          end
        end
        R_ACK: begin
          r_rx_clear <= 1'b0;
          if (!i_rx_ready) r_rx_state <= R_IDLE;
        end
        default: begin
          r_rx_clear <= 1'b0;
          r_rx_state <= R_IDLE;
        end
      endcase
    end
  end

  // TX FSM: load head, hold LOAD until the transmitter reports busy, wait for idle.
  always_ff @(posedge i_clk_100mhz) begin
    if (i_reset) begin
      r_tx_state <= T_IDLE;
      r_tx_load  <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      case (r_tx_state)
        T_IDLE: begin
          if (w_pop) begin
            r_tx_data  <= f_echo(w_head);
            r_tx_load  <= 1'b1;
            r_tx_state <= T_START;
          end
        end
        T_START: begin
          if (i_tx_busy) begin
            r_tx_load  <= 1'b0;
            r_tx_state <= T_DONE;
          end
        end
        T_DONE: begin
          if (!i_tx_busy) r_tx_state <= T_IDLE;
        end
        default: begin
          r_tx_load  <= 1'b0;
          r_tx_state <= T_IDLE;
        end
      endcase
    end
  end

  assign o_rx_clear = r_rx_clear;
  assign o_tx_data  = r_tx_data;
  assign o_tx_load  = r_tx_load;
  assign o_count    = r_count;
  assign o_empty    = r_empty;
  assign o_full     = r_full;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Bench for uart_echo_fifo: one drop-mode instance and one back-pressure
// instance, simple UartRX/UartTX models, and a scoreboard of echoed words.
module tb_uart_echo_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] rx_data_a = '0;
  logic        rx_ready_a = 1'b0;
  logic        flush_a = 1'b0;
  logic        busy_a = 1'b0;
  logic        clear_a, load_a, empty_a, full_a, ovf_a;
  logic [15:0] txd_a;
  logic [3:0]  count_a;

  logic [15:0] rx_data_b = '0;
  logic        rx_ready_b = 1'b0;
  logic        flush_b = 1'b0;
  logic        busy_b = 1'b0;
  logic        clear_b, load_b, empty_b, full_b, ovf_b;
  logic [15:0] txd_b;
  logic [3:0]  count_b;

  int total = 0;
  int bad = 0;
  int mode_a = 0;  // 0: normal UartTX, 1: busy held high, 2: never goes busy
  int mode_b = 0;
  int cnt_a = 0;
  int cnt_b = 0;
  logic [15:0] exp_a[$];
  logic [15:0] obs_a[$];
  logic [15:0] exp_b[$];
  logic [15:0] obs_b[$];
  logic prev_a = 1'b0;
  logic prev_b = 1'b0;

  uart_echo_fifo #(.WIDTH(16), .DEPTH(8), .DROP_NEWEST(1)) u_dut_drop (
    .i_clk_100mhz(clk), .i_reset(rst),
    .i_rx_data(rx_data_a), .i_rx_ready(rx_ready_a), .o_rx_clear(clear_a),
    .o_tx_data(txd_a), .o_tx_load(load_a), .i_tx_busy(busy_a),
    .i_flush(flush_a), .o_count(count_a), .o_empty(empty_a),
    .o_full(full_a), .o_overflow(ovf_a)
  );

  uart_echo_fifo #(.WIDTH(16), .DEPTH(8), .DROP_NEWEST(0)) u_dut_bp (
    .i_clk_100mhz(clk), .i_reset(rst),
    .i_rx_data(rx_data_b), .i_rx_ready(rx_ready_b), .o_rx_clear(clear_b),
    .o_tx_data(txd_b), .o_tx_load(load_b), .i_tx_busy(busy_b),
    .i_flush(flush_b), .o_count(count_b), .o_empty(empty_b),
    .o_full(full_b), .o_overflow(ovf_b)
  );

  // UartTX models: busy for 3 cycles after seeing LOAD, or forced by mode.
  always @(posedge clk) begin
    if (mode_a == 1) busy_a <= 1'b1;
    else if (mode_a == 2) busy_a <= 1'b0;
    else if (cnt_a != 0) begin cnt_a <= cnt_a - 1; busy_a <= (cnt_a != 1); end
    else if (load_a && !busy_a) begin busy_a <= 1'b1; cnt_a <= 3; end
    else busy_a <= 1'b0;
  end

  always @(posedge clk) begin
    if (mode_b == 1) busy_b <= 1'b1;
    else if (mode_b == 2) busy_b <= 1'b0;
    else if (cnt_b != 0) begin cnt_b <= cnt_b - 1; busy_b <= (cnt_b != 1); end
    else if (load_b && !busy_b) begin busy_b <= 1'b1; cnt_b <= 3; end
    else busy_b <= 1'b0;
  end

  // Capture each word handed to the transmitter.
  always @(negedge clk) begin
    if (load_a && !prev_a) obs_a.push_back(txd_a);
    if (load_b && !prev_b) obs_b.push_back(txd_b);
    prev_a = load_a;
    prev_b = load_b;
  end

  function automatic logic [15:0] echo_model(input logic [15:0] d);
    logic [15:0] v;
    v = d;
`ifdef ECHO_UPPERCASE_EN
    if (d[7:0] >= 8'h61 && d[7:0] <= 8'h7A) v = d & 16'hFFDF;
`endif
    return v;
  endfunction

  // UartRX model for instance A: present a word, drop READY once CLEAR is seen.
  task automatic send_a(input logic [15:0] w);
    int n;
    @(negedge clk);
    rx_data_a = w;
    rx_ready_a = 1'b1;
    n = 0;
    while (clear_a !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++;
    if (clear_a !== 1'b1) begin bad++; $display("FAIL send_a_clear: got %b want 1 (word %h)", clear_a, w); end
    rx_ready_a = 1'b0;
  endtask

  task automatic send_b(input logic [15:0] w);
    int n;
    @(negedge clk);
    rx_data_b = w;
    rx_ready_b = 1'b1;
    n = 0;
    while (clear_b !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++;
    if (clear_b !== 1'b1) begin bad++; $display("FAIL send_b_clear: got %b want 1 (word %h)", clear_b, w); end
    rx_ready_b = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (clear_a !== 1'b0) begin bad++; $display("FAIL reset_clear: got %b want 0", clear_a); end
    total++; if (load_a !== 1'b0) begin bad++; $display("FAIL reset_load: got %b want 0", load_a); end
    total++; if (txd_a !== 16'h0000) begin bad++; $display("FAIL reset_txdata: got %h want 0000", txd_a); end
    total++; if (count_a !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count_a); end
    total++; if (empty_a !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", empty_a); end
    total++; if (full_a !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", full_a); end
    total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", ovf_a); end
    total++; if (empty_b !== 1'b1) begin bad++; $display("FAIL reset_empty_b: got %b want 1", empty_b); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int n;
    logic [15:0] o, e;
    @(negedge clk);
    exp_a.push_back(echo_model(16'h0041));
    rx_data_a = 16'h0041;
    rx_ready_a = 1'b1;
    @(negedge clk);
    total++; if (clear_a !== 1'b1) begin bad++; $display("FAIL single_clear: got %b want 1", clear_a); end
    total++; if (count_a !== 4'd1) begin bad++; $display("FAIL single_count1: got %0d want 1", count_a); end
    total++; if (load_a !== 1'b0) begin bad++; $display("FAIL single_load_early: got %b want 0", load_a); end
    rx_ready_a = 1'b0;
    @(negedge clk);
    total++; if (load_a !== 1'b1) begin bad++; $display("FAIL single_load: got %b want 1", load_a); end
    total++; if (txd_a !== 16'h0041) begin bad++; $display("FAIL single_txdata: got %h want 0041", txd_a); end
    total++; if (count_a !== 4'd0) begin bad++; $display("FAIL single_count0: got %0d want 0", count_a); end
    total++; if (clear_a !== 1'b0) begin bad++; $display("FAIL single_clear_pulse: got %b want 0", clear_a); end
    n = 0;
    while (obs_a.size() < 1 && n < 20) begin @(negedge clk); n++; end
    total++; if (obs_a.size() < 1) begin bad++; $display("FAIL single_timeout: got %0d words want 1", obs_a.size()); end
    while (obs_a.size() > 0 && exp_a.size() > 0) begin
      o = obs_a.pop_front(); e = exp_a.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL single_word: got %h want %h", o, e); end
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_burst_fill();
    mode_a = 1;
    repeat (2) @(negedge clk);
    for (int k = 1; k <= 8; k++) begin
      exp_a.push_back(echo_model(16'(k)));
      send_a(16'(k));
    end
    @(negedge clk);
    total++; if (full_a !== 1'b1) begin bad++; $display("FAIL burst_full: got %b want 1", full_a); end
    total++; if (count_a !== 4'd8) begin bad++; $display("FAIL burst_count: got %0d want 8", count_a); end
    total++; if (obs_a.size() != 0) begin bad++; $display("FAIL burst_no_tx: got %0d loads want 0", obs_a.size()); end
  endtask

  task automatic test_drop_newest();
    send_a(16'h00FF);
    @(negedge clk);
    total++; if (ovf_a !== 1'b1) begin bad++; $display("FAIL drop_overflow: got %b want 1", ovf_a); end
    total++; if (count_a !== 4'd8) begin bad++; $display("FAIL drop_count: got %0d want 8", count_a); end
    total++; if (full_a !== 1'b1) begin bad++; $display("FAIL drop_full: got %b want 1", full_a); end
  endtask

  task automatic test_replay();
    int n;
    logic [15:0] o, e;
    mode_a = 0;
    n = 0;
    while (obs_a.size() < 8 && n < 300) begin @(negedge clk); n++; end
    total++; if (obs_a.size() != 8) begin bad++; $display("FAIL replay_count: got %0d words want 8", obs_a.size()); end
    while (obs_a.size() > 0 && exp_a.size() > 0) begin
      o = obs_a.pop_front(); e = exp_a.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL replay_word: got %h want %h", o, e); end
    end
    repeat (10) @(negedge clk);
    total++; if (empty_a !== 1'b1) begin bad++; $display("FAIL replay_empty: got %b want 1", empty_a); end
    total++; if (ovf_a !== 1'b1) begin bad++; $display("FAIL replay_overflow_sticky: got %b want 1", ovf_a); end
  endtask

  task automatic test_flush();
    mode_a = 1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) send_a(16'h0030 + 16'(k));
    repeat (2) @(negedge clk);
    total++; if (count_a !== 4'd5) begin bad++; $display("FAIL flush_pre_count: got %0d want 5", count_a); end
    flush_a = 1'b1;
    @(negedge clk);
    flush_a = 1'b0;
    total++; if (count_a !== 4'd0) begin bad++; $display("FAIL flush_count: got %0d want 0", count_a); end
    total++; if (empty_a !== 1'b1) begin bad++; $display("FAIL flush_empty: got %b want 1", empty_a); end
    total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL flush_overflow: got %b want 0", ovf_a); end
    // Flush in the same cycle as an incoming word: word acked but lost.
    rx_data_a = 16'h0077;
    rx_ready_a = 1'b1;
    flush_a = 1'b1;
    @(negedge clk);
    flush_a = 1'b0;
    total++; if (clear_a !== 1'b1) begin bad++; $display("FAIL flush_push_clear: got %b want 1", clear_a); end
    total++; if (count_a !== 4'd0) begin bad++; $display("FAIL flush_push_count: got %0d want 0", count_a); end
    total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL flush_push_overflow: got %b want 0", ovf_a); end
    rx_ready_a = 1'b0;
    mode_a = 0;
    repeat (20) @(negedge clk);
    total++; if (obs_a.size() != 0) begin bad++; $display("FAIL flush_no_tx: got %0d loads want 0", obs_a.size()); end
  endtask

  task automatic test_uppercase();
    int n;
    logic [15:0] o, e;
    logic [15:0] words [5];
    words[0] = 16'h0061; words[1] = 16'h005A; words[2] = 16'h007B;
    words[3] = 16'h1261; words[4] = 16'h007A;
    for (int k = 0; k < 5; k++) begin
      exp_a.push_back(echo_model(words[k]));
      send_a(words[k]);
    end
    n = 0;
    while (obs_a.size() < 5 && n < 300) begin @(negedge clk); n++; end
    total++; if (obs_a.size() != 5) begin bad++; $display("FAIL upper_count: got %0d words want 5", obs_a.size()); end
    while (obs_a.size() > 0 && exp_a.size() > 0) begin
      o = obs_a.pop_front(); e = exp_a.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL upper_word: got %h want %h", o, e); end
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_backpressure();
    int n;
    logic [15:0] o, e;
    mode_b = 1;
    repeat (2) @(negedge clk);
    for (int k = 1; k <= 8; k++) begin
      exp_b.push_back(echo_model(16'h0100 + 16'(k)));
      send_b(16'h0100 + 16'(k));
    end
    @(negedge clk);
    total++; if (count_b !== 4'd8) begin bad++; $display("FAIL bp_count_full: got %0d want 8", count_b); end
    exp_b.push_back(echo_model(16'h0199));
    rx_data_b = 16'h0199;
    rx_ready_b = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (clear_b !== 1'b0) begin bad++; $display("FAIL bp_clear_held: got %b want 0", clear_b); end
    total++; if (count_b !== 4'd8) begin bad++; $display("FAIL bp_count_held: got %0d want 8", count_b); end
    mode_b = 0;
    n = 0;
    while (load_b !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++; if (txd_b !== echo_model(16'h0101)) begin bad++; $display("FAIL bp_first_pop: got %h want 0101", txd_b); end
    mode_b = 1;
    n = 0;
    while (clear_b !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++; if (clear_b !== 1'b1) begin bad++; $display("FAIL bp_late_clear: got %b want 1", clear_b); end
    total++; if (count_b !== 4'd8) begin bad++; $display("FAIL bp_late_count: got %0d want 8", count_b); end
    total++; if (ovf_b !== 1'b0) begin bad++; $display("FAIL bp_overflow: got %b want 0", ovf_b); end
    rx_ready_b = 1'b0;
    mode_b = 0;
    n = 0;
    while (obs_b.size() < 9 && n < 400) begin @(negedge clk); n++; end
    total++; if (obs_b.size() != 9) begin bad++; $display("FAIL bp_drain_count: got %0d words want 9", obs_b.size()); end
    while (obs_b.size() > 0 && exp_b.size() > 0) begin
      o = obs_b.pop_front(); e = exp_b.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL bp_word: got %h want %h", o, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] o, e;
    mode_a = 2;
    repeat (2) @(negedge clk);
    exp_a.push_back(echo_model(16'h0055));
    send_a(16'h0055);
    send_a(16'h0066);
    @(negedge clk);
    total++; if (load_a !== 1'b1) begin bad++; $display("FAIL rstmid_load_stuck: got %b want 1", load_a); end
    total++; if (count_a !== 4'd1) begin bad++; $display("FAIL rstmid_count_pre: got %0d want 1", count_a); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (load_a !== 1'b0) begin bad++; $display("FAIL rstmid_load: got %b want 0", load_a); end
    total++; if (count_a !== 4'd0) begin bad++; $display("FAIL rstmid_count: got %0d want 0", count_a); end
    total++; if (empty_a !== 1'b1) begin bad++; $display("FAIL rstmid_empty: got %b want 1", empty_a); end
    total++; if (txd_a !== 16'h0000) begin bad++; $display("FAIL rstmid_txdata: got %h want 0000", txd_a); end
    rst = 1'b0;
    mode_a = 0;
    total++; if (obs_a.size() != 1) begin bad++; $display("FAIL rstmid_loads: got %0d want 1", obs_a.size()); end
    while (obs_a.size() > 0 && exp_a.size() > 0) begin
      o = obs_a.pop_front(); e = exp_a.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL rstmid_word: got %h want %h", o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst_fill();
    test_drop_newest();
    test_replay();
    test_flush();
    test_uppercase();
    test_backpressure();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
